// File: rtl/huff_pair_collector.sv
// huff_pair_collector
//   Collects decoded big-value Huffman pairs for one granule and writes them
//   to the granule RAM, then zero-fills the remaining pair slots so every
//   address 0..NUM_PAIRS-1 is written exactly once per granule.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start                         one-cycle pulse, begins a granule (IDLE only)
//   big_values                    number of big-value pairs
//   region1_start, region2_start  first pair index of regions 1 and 2
//   table_select0/1/2             Huffman table per region
//   axiiv, x_val, y_val           decoded pair from the Huffman decoder
//   decode_en                     decoder may consume bits (DECODE state)
//   cur_table                     table for the next pair
//   wr_en, wr_addr, wr_data       granule RAM write port, data = {x, y}
//   last_nz                       one past the highest nonzero pair index
//   overrun                       sticky: pair arrived outside DECODE
//   done                          one-cycle pulse, granule fully written
module huff_pair_collector #(
   parameter int NUM_PAIRS = 288
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [8:0]         big_values,
   input  logic [8:0]         region1_start,
   input  logic [8:0]         region2_start,
   input  logic [4:0]         table_select0,
   input  logic [4:0]         table_select1,
   input  logic [4:0]         table_select2,
   input  logic               axiiv,
   input  logic signed [15:0] x_val,
   input  logic signed [15:0] y_val,
   output logic               decode_en,
   output logic [4:0]         cur_table,
   output logic               wr_en,
   output logic [8:0]         wr_addr,
   output logic [31:0]        wr_data,
   output logic [8:0]         last_nz,
   output logic               overrun,
   output logic               done
);

   localparam logic [8:0] NP = 9'(NUM_PAIRS);

   typedef enum logic [1:0] {IDLE, DECODE, ZERO_FILL, DONE} state_t;

   state_t     state, state_nxt;
   logic [8:0] bv, r1, r2, pair_idx;
   logic [4:0] ts0, ts1, ts2;
   logic [8:0] bv_in, r1_in, r2_lo, r2_in;

   // Region bounds are clamped so that 0 <= r1 <= r2 <= bv <= NUM_PAIRS.
   always_comb begin
      bv_in = (big_values > NP) ? NP : big_values;
      r1_in = (region1_start > bv_in) ? bv_in : region1_start;
      r2_lo = (region2_start < r1_in) ? r1_in : region2_start;
      r2_in = (r2_lo > bv_in) ? bv_in : r2_lo;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start) state_nxt = (bv_in != 9'd0) ? DECODE : ZERO_FILL;
         DECODE:    if (axiiv && (pair_idx == bv - 9'd1)) state_nxt = ZERO_FILL;
         // pair_idx == NP only when bv == NP: nothing to fill, leave at once.
         ZERO_FILL: if (pair_idx >= NP - 9'd1) state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign decode_en = (state == DECODE);
   assign done      = (state == DONE);
   assign cur_table = (pair_idx < r1) ? ts0 : (pair_idx < r2) ? ts1 : ts2;

   always_ff @(posedge clk) begin
      if (rst) begin
         bv       <= '0;
         r1       <= '0;
         r2       <= '0;
         ts0      <= '0;
         ts1      <= '0;
         ts2      <= '0;
         pair_idx <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         last_nz  <= '0;
         overrun  <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (axiiv && (state != DECODE)) overrun <= 1'b1;
         case (state)
            IDLE: if (start) begin
               bv       <= bv_in;
               r1       <= r1_in;
               r2       <= r2_in;
               ts0      <= table_select0;
               ts1      <= table_select1;
               ts2      <= table_select2;
               pair_idx <= '0;
               last_nz  <= '0;
               overrun  <= 1'b0;
            end
            DECODE: if (axiiv) begin
               wr_en    <= 1'b1;
               wr_addr  <= pair_idx;
               wr_data  <= {x_val, y_val};
               pair_idx <= pair_idx + 9'd1;
               if ((x_val != 16'sd0) || (y_val != 16'sd0)) last_nz <= pair_idx + 9'd1;
            end
            ZERO_FILL: if (pair_idx < NP) begin
               wr_en    <= 1'b1;
               wr_addr  <= pair_idx;
               wr_data  <= '0;
               pair_idx <= pair_idx + 9'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
